processor_mc: RTL and testbench
===============================

PROCESSOR_MC -- requirements
Module: processor_mc

Interface
Parameters (name, default, meaning):
REQ-001 DATA_W, 32, datapath and register width; the block SHALL reject values below 32 at elaboration.
REQ-002 ADDR_W, 16, word-address width of the memory port and the PC.
REQ-003 NREG_LOG2, 5, log2 of the register count; rs/rt/rd fields SHALL be truncated to NREG_LOG2 bits.
REQ-004 RESET_PC, 0, PC value loaded on reset.

Ports (name, direction, width, meaning):
REQ-005 clk, in, 1, single clock; all state SHALL update on its rising edge.
REQ-006 rst_n, in, 1, reset: asynchronous, active-low.
REQ-007 mem_req, out, 1, memory access request.
REQ-008 mem_we, out, 1, 1 = write, 0 = read; qualified by mem_req.
REQ-009 mem_addr, out, ADDR_W, word address.
REQ-010 mem_wdata, out, DATA_W, store data.
REQ-011 mem_rdata, in, DATA_W, read data, valid in the cycle mem_ready=1; instruction = mem_rdata[31:0].
REQ-012 mem_ready, in, 1, access complete.
REQ-013 pc_o, out, ADDR_W, current PC.
REQ-014 retire, out, 1, one-cycle pulse per completed instruction.
REQ-015 halted, out, 1, core stopped; err, out, 1, stopped on an illegal opcode.

Function
REQ-016 The PC SHALL be word-addressed: the sequential next PC is PC+1 and the branch target is PC+1+sext(imm16), both modulo 2^ADDR_W.
REQ-017 Decoded opcodes SHALL be R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), addi 001000, lw 100011, sw 101011, beq 000100, j 000010, and halt 111111.
REQ-018 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready=1 latch IR and go to DECODE; otherwise stay.
REQ-020 DECODE: latch A=reg[rs], B=reg[rt] and the branch target; halt opcode -> HALT; unknown opcode or R-type funct -> HALT with err=1; otherwise -> EXEC.
REQ-021 EXEC: compute ALUOut (add/sub/and/or/slt; addi, lw and sw use A+sext(imm16)).
REQ-022 From EXEC: beq sets PC to the target if A==B, else PC+1, then FETCH; j sets PC=zero-extended/truncated IR[25:0], then FETCH; lw/sw -> MEM; R-type/addi -> WB.
REQ-023 MEM: mem_req=1, mem_addr=ALUOut[ADDR_W-1:0], mem_we=1 for sw with mem_wdata=B; on mem_ready, sw sets PC+1 and goes to FETCH, lw latches MDR=mem_rdata and goes to WB.
REQ-024 WB: write ALUOut (R-type to rd, addi to rt) or MDR (lw to rt); set PC+1; go to FETCH.
REQ-025 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-026 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.
REQ-027 mem_ready=1 SHALL be ignored outside FETCH and MEM.
REQ-028 Register 0 SHALL read 0; writes to register 0 SHALL be discarded.
REQ-029 slt SHALL be a signed DATA_W compare; add/sub SHALL wrap modulo 2^DATA_W with no exception.
REQ-030 retire SHALL pulse in the final cycle of each beq, j, sw or WB, and SHALL NOT pulse for halt or illegal opcodes.
REQ-031 Cycle counts with zero-wait memory: R-type/addi 4, lw 5, sw 4, beq/j 3.
REQ-032 HALT SHALL be terminal until reset; halted=1, and PC holds the halt instruction's address.

Reset
REQ-033 While rst_n=0: state=FETCH, PC=RESET_PC, mem_req=0, retire=0, halted=0, err=0, all registers 0.
REQ-034 A reset asserted mid-access SHALL abort the transaction immediately; the first request after reset release SHALL be a fetch at RESET_PC.

Verification
REQ-035 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt -> r3=2, 3 retire pulses, halted=1, pc_o=3.
REQ-036 sw r1,8(r0), then lw r4,8(r0), with memory holding mem_ready low for 3 cycles each access -> mem_addr=8 and mem_wdata=5 stay stable through the stall, r4=5.
REQ-037 beq r1,r1,-1 at PC 4 -> PC returns to 4 (a loop), retire every 3 cycles; beq with A!=B at PC 4 -> PC=5.
REQ-038 slt r5,r2,r1 with r2=-3, r1=5 -> r5=1; add r0,r1,r1 -> r0 still reads 0.
REQ-039 Opcode 010001 -> halted=1, err=1, no retire pulse; rst_n pulsed low during a stalled fetch -> mem_req=0 at once, then a fetch at RESET_PC.

Source files
------------

// File: rtl/processor_mc.sv
`default_nettype none
// ============================================================================
// Module   : processor_mc
// Purpose  : Multi-cycle 32-bit MIPS-subset core with one shared memory port.
//            Each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB].
//            halt or an illegal opcode parks the core in HALT until reset.
// Ports    : clk, rst_n (async, active-low)
//            mem_req/mem_we/mem_addr/mem_wdata -> memory request (held stable
//            until mem_ready); mem_rdata/mem_ready <- memory response
//            pc_o current PC, retire one pulse per completed instruction,
//            halted core stopped, err stopped on an illegal instruction
// Revision : 1.0 - initial release
// ============================================================================
module processor_mc #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 16,
   parameter int                NREG_LOG2 = 5,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_o,
   output logic              retire,
   output logic              halted,
   output logic              err
);

   generate
      if (DATA_W < 32) begin : g_dataWidthCheck
         $error("processor_mc: DATA_W must be at least 32");
      end
   endgenerate

   localparam int         c_numRegs = 1 << NREG_LOG2;
   localparam logic [5:0] c_opRType = 6'b000000;
   localparam logic [5:0] c_opAddi  = 6'b001000;
   localparam logic [5:0] c_opLw    = 6'b100011;
   localparam logic [5:0] c_opSw    = 6'b101011;
   localparam logic [5:0] c_opBeq   = 6'b000100;
   localparam logic [5:0] c_opJ     = 6'b000010;
   localparam logic [5:0] c_opHalt  = 6'b111111;
   localparam logic [5:0] c_fnAdd   = 6'b100000;
   localparam logic [5:0] c_fnSub   = 6'b100010;
   localparam logic [5:0] c_fnAnd   = 6'b100100;
   localparam logic [5:0] c_fnOr    = 6'b100101;
   localparam logic [5:0] c_fnSlt   = 6'b101010;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t r_state, w_nextState;

   logic [ADDR_W-1:0]    r_pc, r_target;
   logic [31:0]          r_ir;
   logic [DATA_W-1:0]    r_a, r_b, r_aluOut, r_mdr;
   logic                 r_err;
   logic [DATA_W-1:0]    r_regs [c_numRegs];

   logic [5:0]           w_op, w_funct;
   logic [NREG_LOG2-1:0] w_rs, w_rt, w_rd, w_wbDst;
   logic [DATA_W-1:0]    w_immData, w_regA, w_regB, w_aluResult, w_wbData;
   logic [ADDR_W-1:0]    w_immAddr, w_pcNext, w_jumpPc;
   logic                 w_isRType, w_isAddi, w_isLw, w_isSw, w_isBeq, w_isJ, w_isHalt;
   logic                 w_functOk, w_legal;

   // ---------------------------------------------------------------- decode
   assign w_op      = r_ir[31:26];
   assign w_funct   = r_ir[5:0];
   assign w_rs      = NREG_LOG2'(r_ir[25:21]);
   assign w_rt      = NREG_LOG2'(r_ir[20:16]);
   assign w_rd      = NREG_LOG2'(r_ir[15:11]);
   assign w_immData = DATA_W'($signed(r_ir[15:0]));
   assign w_immAddr = ADDR_W'($signed(r_ir[15:0]));
   assign w_jumpPc  = ADDR_W'(r_ir[25:0]);
   assign w_pcNext  = r_pc + ADDR_W'(1);

   assign w_isRType = (w_op == c_opRType);
   assign w_isAddi  = (w_op == c_opAddi);
   assign w_isLw    = (w_op == c_opLw);
   assign w_isSw    = (w_op == c_opSw);
   assign w_isBeq   = (w_op == c_opBeq);
   assign w_isJ     = (w_op == c_opJ);
   assign w_isHalt  = (w_op == c_opHalt);

   assign w_functOk = (w_funct == c_fnAdd) || (w_funct == c_fnSub) || (w_funct == c_fnAnd) ||
                      (w_funct == c_fnOr)  || (w_funct == c_fnSlt);
   assign w_legal   = w_isRType ? w_functOk : (w_isAddi || w_isLw || w_isSw || w_isBeq || w_isJ);

   // Register 0 is never written, but reads are forced to zero regardless.
   assign w_regA = (w_rs == '0) ? '0 : r_regs[w_rs];
   assign w_regB = (w_rt == '0) ? '0 : r_regs[w_rt];

   // R-type writes rd; addi and lw write rt.
   assign w_wbDst  = w_isRType ? w_rd : w_rt;
   assign w_wbData = w_isLw ? r_mdr : r_aluOut;

   // ------------------------------------------------------------------ ALU
   always_comb begin
      w_aluResult = r_a + w_immData;
      if (w_isRType) begin
         case (w_funct)
            c_fnSub: w_aluResult = r_a - r_b;
            c_fnAnd: w_aluResult = r_a & r_b;
            c_fnOr:  w_aluResult = r_a | r_b;
            c_fnSlt: w_aluResult = DATA_W'($signed(r_a) < $signed(r_b));
            default: w_aluResult = r_a + r_b;
         endcase
      end
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = r_pc;
      retire      = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               w_nextState = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_isHalt || !w_legal) begin
               w_nextState = S_HALT;
            end else begin
               w_nextState = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_isBeq || w_isJ) begin
               retire      = 1'b1;
               w_nextState = S_FETCH;
            end else if (w_isLw || w_isSw) begin
               w_nextState = S_MEM;
            end else begin
               w_nextState = S_WB;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = w_isSw;
            mem_addr = ADDR_W'(r_aluOut);
            if (mem_ready) begin
               retire      = w_isSw;
               w_nextState = w_isSw ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            retire      = 1'b1;
            w_nextState = S_FETCH;
         end
         S_HALT: begin
            w_nextState = S_HALT;
         end
         default: begin
            w_nextState = S_FETCH;
         end
      endcase
      // The state register sits in FETCH during reset; keep the port quiet
      // so an access in flight is dropped the moment rst_n falls.
      if (!rst_n) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         retire  = 1'b0;
      end
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_target <= '0;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_aluOut <= '0;
         r_mdr    <= '0;
         r_err    <= 1'b0;
         for (int i = 0; i < c_numRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir <= mem_rdata[31:0];
               end
            end
            S_DECODE: begin
               r_a      <= w_regA;
               r_b      <= w_regB;
               r_target <= w_pcNext + w_immAddr;
               if (!w_isHalt && !w_legal) begin
                  r_err <= 1'b1;
               end
            end
            S_EXEC: begin
               r_aluOut <= w_aluResult;
               if (w_isBeq) begin
                  r_pc <= (r_a == r_b) ? r_target : w_pcNext;
               end else if (w_isJ) begin
                  r_pc <= w_jumpPc;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (w_isSw) begin
                     r_pc <= w_pcNext;
                  end else begin
                     r_mdr <= mem_rdata;
                  end
               end
            end
            S_WB: begin
               if (w_wbDst != '0) begin
                  r_regs[w_wbDst] <= w_wbData;
               end
               r_pc <= w_pcNext;
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_wdata = r_b;
   assign pc_o      = r_pc;
   assign halted    = (r_state == S_HALT);
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_processor_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_mc
// Purpose  : Self-checking bench for processor_mc. An instruction-level
//            interpreter predicts the ordered stream of memory accesses and
//            retire pulses; a memory responder with configurable wait states
//            serves the core and a monitor compares every handshake/retire
//            against the predicted stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_processor_mc;
   localparam int          DATA_W    = 32;
   localparam int          ADDR_W    = 16;
   localparam int          NREG_LOG2 = 5;
   localparam logic [15:0] RESET_PC  = 16'd0;

   localparam int K_FETCH  = 0;
   localparam int K_LOAD   = 1;
   localparam int K_STORE  = 2;
   localparam int K_RETIRE = 3;

   localparam logic [31:0] c_HALT = 32'hFC00_0000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              mem_req, mem_we, mem_ready;
   logic [ADDR_W-1:0] mem_addr, pc_o;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              retire, halted, err;

   processor_mc #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG_LOG2(NREG_LOG2), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .pc_o(pc_o), .retire(retire), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t         expQ[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] dmem [256];
   logic [31:0] prog [256];
   int          waitMode = 0;   // <0: random waits + spurious ready, else fixed waits
   bit          monArmed = 1'b0;
   int          retireCnt = 0;
   int          retireCyc[$];
   int          cycNow = 0;
   logic [15:0] mHaltPc;
   bit          mErr;
   int          mCycles;
   logic [15:0] endPc;
   int          endRetires;

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   // ------------------------------------------------------------ encoders
   function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] jType(input int target);
      return {6'b000010, 26'(target)};
   endfunction

   function automatic void clearProg();
      foreach (prog[i]) prog[i] = 32'd0;
   endfunction

   // ------------------------------------------------------ reference model
   // Instruction-set interpreter: each instruction contributes its fetch,
   // its data access and its retire to the expected event stream.
   function automatic void runModel(input int maxSteps);
      logic [31:0] mm [256];
      logic [31:0] regs [32];
      logic [15:0] pc, addr;
      logic [31:0] ins, a, b, res, simm, sum;
      logic [5:0]  op, fn;
      int          rs, rt, rd;
      bit          bad;
      foreach (mm[i]) mm[i] = prog[i];
      foreach (regs[i]) regs[i] = 32'd0;
      pc = RESET_PC; mErr = 1'b0; mCycles = 0; mHaltPc = 16'hxxxx;
      expQ.delete();
      for (int s = 0; s < maxSteps; s++) begin
         ins = mm[pc[7:0]];
         expQ.push_back('{kind: K_FETCH, addr: pc, data: 32'd0});
         op = ins[31:26]; fn = ins[5:0];
         rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
         a = regs[rs]; b = regs[rt];
         simm = {{16{ins[15]}}, ins[15:0]};
         sum = a + simm;
         addr = sum[15:0];
         bad = 1'b0;
         res = 32'd0;
         if (op == 6'b000000) begin
            case (fn)
               6'b100000: res = a + b;
               6'b100010: res = a - b;
               6'b100100: res = a & b;
               6'b100101: res = a | b;
               6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default:   bad = 1'b1;
            endcase
         end else if (!(op inside {6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010})) begin
            bad = 1'b1;
         end
         if (op == 6'b111111 || bad) begin
            mHaltPc = pc; mErr = (op != 6'b111111); mCycles += 2;
            break;
         end
         case (op)
            6'b000000: begin
               expQ.push_back('{kind: K_RETIRE, addr: pc, data: 32'd0});
               if (rd != 0) regs[rd] = res;
               pc++; mCycles += 4;
            end
            6'b001000: begin
               expQ.push_back('{kind: K_RETIRE, addr: pc, data: 32'd0});
               if (rt != 0) regs[rt] = sum;
               pc++; mCycles += 4;
            end
            6'b100011: begin
               expQ.push_back('{kind: K_LOAD, addr: addr, data: 32'd0});
               expQ.push_back('{kind: K_RETIRE, addr: pc, data: 32'd0});
               if (rt != 0) regs[rt] = mm[addr[7:0]];
               pc++; mCycles += 5;
            end
            6'b101011: begin
               expQ.push_back('{kind: K_STORE, addr: addr, data: b});
               expQ.push_back('{kind: K_RETIRE, addr: pc, data: 32'd0});
               mm[addr[7:0]] = b;
               pc++; mCycles += 4;
            end
            6'b000100: begin
               expQ.push_back('{kind: K_RETIRE, addr: pc, data: 32'd0});
               pc = (a == b) ? (pc + 16'd1 + simm[15:0]) : (pc + 16'd1);
               mCycles += 3;
            end
            default: begin
               expQ.push_back('{kind: K_RETIRE, addr: pc, data: 32'd0});
               pc = ins[15:0];
               mCycles += 3;
            end
         endcase
      end
   endfunction

   // ---------------------------------------------------- memory responder
   initial begin
      bit          pending;
      int          waitLeft;
      logic [48:0] cap;
      pending = 1'b0; waitLeft = 0; cap = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pending = 1'b0; mem_ready = 1'b0;
         end else if (mem_req) begin
            if (!pending) begin
               pending  = 1'b1;
               cap      = {mem_we, mem_addr, mem_wdata};
               waitLeft = (waitMode < 0) ? int'($urandom_range(0, 3)) : waitMode;
            end else begin
               chk("stallStable", {mem_we, mem_addr, mem_wdata}, cap);
            end
            if (waitLeft == 0) begin
               mem_ready = 1'b1;
               mem_rdata = dmem[mem_addr[7:0]];
               if (mem_we) dmem[mem_addr[7:0]] = mem_wdata;
               pending = 1'b0;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom();
               waitLeft--;
            end
         end else begin
            pending   = 1'b0;
            mem_ready = (waitMode < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom();
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cycNow++;
   end

   // -------------------------------------------------------------- monitor
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && monArmed) begin
            if (mem_req && mem_ready) begin
               if (expQ.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL access: got access addr=%0h we=%0b, required no event", mem_addr, mem_we);
               end else begin
                  e = expQ.pop_front();
                  if (e.kind == K_RETIRE) begin
                     checks++; errors++;
                     $display("FAIL access: got access addr=%0h, required retire of pc %0h", mem_addr, e.addr);
                  end else begin
                     chk("accessWe", mem_we, (e.kind == K_STORE));
                     chk("accessAddr", mem_addr, e.addr);
                     if (e.kind == K_STORE) chk("storeData", mem_wdata, e.data);
                  end
               end
            end
            if (retire) begin
               retireCnt++;
               retireCyc.push_back(cycNow);
               if (expQ.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL retire: got retire at pc %0h, required no event", pc_o);
               end else begin
                  e = expQ.pop_front();
                  if (e.kind != K_RETIRE) begin
                     checks++; errors++;
                     $display("FAIL retire: got retire at pc %0h, required access kind %0d addr %0h", pc_o, e.kind, e.addr);
                  end else begin
                     chk("retirePc", pc_o, e.addr);
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ test task
   // Expects rst_n low on entry; leaves rst_n low on exit.
   task automatic runProg(input string name, input int wm, input int maxSteps,
                          input bit waitHalt, input bit checkCycles);
      int cyc;
      bit done;
      foreach (dmem[i]) dmem[i] = prog[i];
      runModel(maxSteps);
      waitMode = wm; retireCnt = 0; retireCyc.delete();
      monArmed = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b1;
      cyc = 0; done = 1'b0;
      while (!done && cyc < 3000) begin
         @(posedge clk); cyc++;
         @(negedge clk); #2;
         if (waitHalt ? (halted === 1'b1) : (expQ.size() == 0)) done = 1'b1;
      end
      monArmed = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s.timeout: got no completion after %0d cycles, required completion", name, cyc);
      end
      if (waitHalt) begin
         chk({name, ".halted"}, halted, 1);
         chk({name, ".err"}, err, mErr);
         chk({name, ".haltPc"}, pc_o, mHaltPc);
         chk({name, ".leftover"}, expQ.size(), 0);
         if (checkCycles) chk({name, ".cycles"}, cyc, mCycles);
      end
      endPc = pc_o; endRetires = retireCnt;
      rst_n = 1'b0;
      #1;
      chk({name, ".rstReq"}, mem_req, 0);
      chk({name, ".rstHalted"}, halted, 0);
      chk({name, ".rstErr"}, err, 0);
      chk({name, ".rstPc"}, pc_o, RESET_PC);
      @(posedge clk);
   endtask

   task automatic genRandomProg();
      logic [5:0] fns [5];
      int n, r, off;
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      clearProg();
      n = 20;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 9));
         off = int'($urandom_range(0, 2));
         case (r)
            5: prog[i] = iType(6'b001000, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom()));
            6: prog[i] = iType(6'b100011, 0, int'($urandom_range(0, 7)), 16'($urandom_range(64, 95)));
            7: prog[i] = iType(6'b101011, 0, int'($urandom_range(0, 7)), 16'($urandom_range(64, 95)));
            8: prog[i] = iType(6'b000100, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'(off));
            9: prog[i] = jType(i + 1 + off);
            default: prog[i] = rType(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                     int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
         endcase
      end
      for (int k = 1; k < 8; k++) prog[n + k - 1] = iType(6'b101011, 0, k, 16'(96 + k));
      prog[n + 7] = c_HALT;
      for (int k = 64; k < 96; k++) prog[k] = $urandom();
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.memReq", mem_req, 0);
      chk("reset.retire", retire, 0);
      chk("reset.halted", halted, 0);
      chk("reset.err", err, 0);
      chk("reset.pc", pc_o, RESET_PC);

      // addi/addi/add/halt, zero-wait memory
      clearProg();
      prog[0] = iType(6'b001000, 0, 1, 16'd5);
      prog[1] = iType(6'b001000, 0, 2, 16'hFFFD);
      prog[2] = rType(1, 2, 3, 6'b100000);
      prog[3] = c_HALT;
      runProg("basic", 0, 100, 1'b1, 1'b1);
      chk("basic.pcConst", endPc, 3);
      chk("basic.retires", endRetires, 3);

      // same, with r3 made visible through a store
      prog[3] = iType(6'b101011, 0, 3, 16'd64);
      prog[4] = c_HALT;
      runProg("basicStore", 0, 100, 1'b1, 1'b1);

      // store/load through a 3-cycle stalling memory
      clearProg();
      prog[0] = iType(6'b001000, 0, 1, 16'd5);
      prog[1] = iType(6'b101011, 0, 1, 16'd8);
      prog[2] = iType(6'b100011, 0, 4, 16'd8);
      prog[3] = iType(6'b101011, 0, 4, 16'd9);
      prog[4] = c_HALT;
      runProg("stall", 3, 100, 1'b1, 1'b0);
      chk("stall.retires", endRetires, 4);

      // beq r1,r1,-1 at PC 4: tight loop
      clearProg();
      prog[0] = iType(6'b001000, 0, 1, 16'd5);
      prog[1] = iType(6'b001000, 0, 2, 16'd7);
      prog[2] = iType(6'b001000, 0, 0, 16'd0);
      prog[3] = iType(6'b001000, 0, 0, 16'd0);
      prog[4] = iType(6'b000100, 1, 1, 16'hFFFF);
      runProg("loop", 0, 8, 1'b0, 1'b0);
      chk("loop.retires", endRetires, 8);
      if (retireCyc.size() >= 2)
         chk("loop.period", retireCyc[retireCyc.size() - 1] - retireCyc[retireCyc.size() - 2], 3);
      else
         chk("loop.retireLog", retireCyc.size(), 2);

      // beq not taken at PC 4
      prog[4] = iType(6'b000100, 1, 2, 16'hFFFF);
      prog[5] = c_HALT;
      runProg("beqNot", 0, 100, 1'b1, 1'b1);
      chk("beqNot.pcConst", endPc, 5);

      // slt with signed operands and write to r0
      clearProg();
      prog[0] = iType(6'b001000, 0, 1, 16'd5);
      prog[1] = iType(6'b001000, 0, 2, 16'hFFFD);
      prog[2] = rType(2, 1, 5, 6'b101010);
      prog[3] = rType(1, 1, 0, 6'b100000);
      prog[4] = iType(6'b101011, 0, 5, 16'd64);
      prog[5] = iType(6'b101011, 0, 0, 16'd65);
      prog[6] = c_HALT;
      runProg("sltR0", -1, 100, 1'b1, 1'b0);

      // illegal opcode, then illegal R-type funct
      clearProg();
      prog[0] = iType(6'b001000, 0, 1, 16'd5);
      prog[1] = {6'b010001, 26'd0};
      runProg("illegalOp", 0, 100, 1'b1, 1'b1);
      chk("illegalOp.errConst", mErr, 1);
      chk("illegalOp.retires", endRetires, 1);
      prog[1] = rType(1, 1, 2, 6'b000111);
      runProg("illegalFn", 0, 100, 1'b1, 1'b1);
      chk("illegalFn.retires", endRetires, 1);

      // reset pulsed in the middle of a stalled fetch
      clearProg();
      prog[0] = iType(6'b001000, 0, 1, 16'd5);
      prog[1] = iType(6'b001000, 0, 2, 16'hFFFD);
      prog[2] = rType(1, 2, 3, 6'b100000);
      prog[3] = c_HALT;
      foreach (dmem[i]) dmem[i] = prog[i];
      waitMode = 8; monArmed = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      chk("abort.preReq", mem_req, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.memReq", mem_req, 0);
      chk("abort.retire", retire, 0);
      @(posedge clk);
      runProg("afterAbort", 0, 100, 1'b1, 1'b1);

      // randomized programs with random wait states
      for (int t = 0; t < 25; t++) begin
         genRandomProg();
         runProg($sformatf("rand%0d", t), -1, 200, 1'b1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
